// File: rtl/axi_vip_lite_wr_master.sv
// axi_vip_lite_wr_master
// Lightweight AXI4-Lite write master. Commands (address, data, strobe) are
// queued in a small FIFO and issued one at a time on AW and W. Both channels
// are raised together and may complete in either order. Write responses are
// collected on B. A one-cycle status pulse and an error counter report each
// response.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (cmd_ready is registered)
//   cmd_addr, cmd_data, cmd_strb  command payload
//   AWADDR/AWVALID/AWREADY        AXI write address channel
//   WDATA/WSTRB/WVALID/WREADY     AXI write data channel
//   BRESP/BVALID/BREADY           AXI write response channel
//   rsp_valid, rsp_resp           one-cycle pulse per response, with its code
//   outstanding                   writes issued and still waiting for B
//   err_cnt                       saturating count of non-OKAY responses
//   idle                          nothing queued, nothing issuing, nothing in flight
module axi_vip_lite_wr_master #(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int CMD_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] cmd_strb,
  output logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
  output logic                        AWVALID,
  input  logic                        AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]   WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
  output logic                        WVALID,
  input  logic                        WREADY,
  input  logic [1:0]                  BRESP,
  input  logic                        BVALID,
  output logic                        BREADY,
  output logic                        rsp_valid,
  output logic [1:0]                  rsp_resp,
  output logic [3:0]                  outstanding,
  output logic [15:0]                 err_cnt,
  output logic                        idle
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int PTR_W  = $clog2(CMD_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(CMD_DEPTH);
  localparam logic [PTR_W:0] ONE_C   = (PTR_W + 1)'(1);
  localparam logic [4:0]     MAX_C   = 5'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_W, WAIT_AW} state_t;

  state_t state, state_nxt;

  logic [AXI_ADDR_WIDTH-1:0] addr_mem [CMD_DEPTH];
  logic [AXI_DATA_WIDTH-1:0] data_mem [CMD_DEPTH];
  logic [STRB_W-1:0]         strb_mem [CMD_DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr, nxt_idx;
  logic [PTR_W:0]   count, count_nxt;

  logic push, pop, aw_hs, w_hs, b_hs;
  logic complete, load, bypass, permit_idle, permit_after;
  logic [4:0] out_ext, out_dec, out_after;

  logic [AXI_ADDR_WIDTH-1:0] load_addr;
  logic [AXI_DATA_WIDTH-1:0] load_data;
  logic [STRB_W-1:0]         load_strb;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign push   = cmd_valid & cmd_ready;
  assign pop    = complete;
  assign aw_hs  = AWVALID & AWREADY;
  assign w_hs   = WVALID & WREADY;
  assign BREADY = (outstanding != 4'd0);
  assign b_hs   = BVALID & BREADY;

  assign AWVALID = (state == ISSUE) || (state == WAIT_AW);
  assign WVALID  = (state == ISSUE) || (state == WAIT_W);
  assign idle    = (count == '0) && (state == IDLE) && (outstanding == 4'd0);

  assign count_nxt = count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);

  // A B handshake in this cycle already frees its slot for the issue decision.
  assign out_ext   = {1'b0, outstanding};
  assign out_dec   = out_ext - {4'd0, b_hs};
  assign out_after = out_dec + 5'd1;

  assign permit_idle  = (count != '0) && (out_dec < MAX_C);
  // After a pop the next entry is either still in the FIFO or is the command
  // being pushed this very cycle; the latter is taken straight from the
  // command inputs so a streaming source sees no bubble.
  assign permit_after = ((count > ONE_C) || push) && (out_after < MAX_C);
  assign bypass       = complete && (count == ONE_C);
  assign nxt_idx      = complete ? rd_ptr + PTR_W'(1) : rd_ptr;

  always_comb begin
    load_addr = addr_mem[nxt_idx];
    load_data = data_mem[nxt_idx];
    load_strb = strb_mem[nxt_idx];
    if (bypass) begin
      load_addr = cmd_addr;
      load_data = cmd_data;
      load_strb = cmd_strb;
    end
  end

  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (permit_idle) begin
          state_nxt = ISSUE;
          load      = 1'b1;
        end
      end
      ISSUE: begin
        if (aw_hs && w_hs) complete = 1'b1;
        else if (aw_hs)    state_nxt = WAIT_W;
        else if (w_hs)     state_nxt = WAIT_AW;
      end
      WAIT_W:  if (w_hs)  complete = 1'b1;
      WAIT_AW: if (aw_hs) complete = 1'b1;
      default: state_nxt = IDLE;
    endcase
    if (complete) begin
      if (permit_after) begin
        state_nxt = ISSUE;
        load      = 1'b1;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  // Command FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= cmd_addr;
      data_mem[wr_ptr] <= cmd_data;
      strb_mem[wr_ptr] <= cmd_strb;
    end
  end

  // FIFO pointers and registered ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_nxt;
      cmd_ready <= (count_nxt != DEPTH_C);
    end
  end

  // Issue FSM and channel payload registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      AWADDR <= '0;
      WDATA  <= '0;
      WSTRB  <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        AWADDR <= load_addr;
        WDATA  <= load_data;
        WSTRB  <= load_strb;
      end
    end
  end

  // Response tracking and status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= 4'd0;
      rsp_valid   <= 1'b0;
      rsp_resp    <= 2'b00;
      err_cnt     <= 16'd0;
    end else begin
      outstanding <= 4'(out_dec + {4'd0, complete});
      rsp_valid   <= b_hs;
      if (b_hs) begin
        rsp_resp <= BRESP;
        if (BRESP != 2'b00) err_cnt <= sat_inc16(err_cnt);
      end
    end
  end

endmodule

// File: tb/tb_axi_vip_lite_wr_master.sv
// Testbench for axi_vip_lite_wr_master: randomized AXI slave behaviour and
// command traffic, checked every cycle against a transaction-level model
// (expected-write queue plus handshake counters).
module tb_axi_vip_lite_wr_master;
  localparam int AW = 32, DW = 32, SW = 4, DEPTH = 4, MAXO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr, AWADDR;
  logic [DW-1:0] cmd_data, WDATA;
  logic [SW-1:0] cmd_strb, WSTRB;
  logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, rsp_valid, idle;
  logic [1:0] BRESP, rsp_resp;
  logic [3:0] outstanding;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  axi_vip_lite_wr_master #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .CMD_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .rsp_valid(rsp_valid), .rsp_resp(rsp_resp),
    .outstanding(outstanding), .err_cnt(err_cnt), .idle(idle)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } cmd_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  cmd_t exp_q[$];
  cmd_t pend_q[$];
  int acc_n, aw_n, w_n, b_n, pop_n, errs;
  bit prev_rst, prev_bhs, aw_wait_p, w_wait_p;
  logic [1:0] prev_bresp;
  logic [AW-1:0] awaddr_p;
  logic [DW-1:0] wdata_p;
  logic [SW-1:0] wstrb_p;
  int wait_aw_cyc;

  // Stimulus modes: 0 low, 1 high, 2 random; bresp: 0 OKAY, 1 SLVERR, 2 random
  int awr_m, wr_m, bv_m, br_m;
  bit stream;

  function automatic int done_n();
    return (aw_n < w_n) ? aw_n : w_n;
  endfunction

  function automatic logic mode_v(input int m);
    if (m == 0) return 1'b0;
    if (m == 1) return 1'b1;
    return 1'($urandom);
  endfunction

  always @(negedge clk) begin
    int comp, outm, idx;
    logic [15:0] err_exp;
    if (rst) begin
      chk("rst_awvalid", 64'(AWVALID), 64'(0));
      chk("rst_wvalid", 64'(WVALID), 64'(0));
      chk("rst_bready", 64'(BREADY), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_resp", 64'(rsp_resp), 64'(0));
      chk("rst_outstanding", 64'(outstanding), 64'(0));
      chk("rst_err_cnt", 64'(err_cnt), 64'(0));
      chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
      chk("rst_idle", 64'(idle), 64'(1));
      chk("rst_awaddr", 64'(AWADDR), 64'(0));
      chk("rst_wdata", 64'(WDATA), 64'(0));
      chk("rst_wstrb", 64'(WSTRB), 64'(0));
      exp_q.delete();
      acc_n = 0; aw_n = 0; w_n = 0; b_n = 0; pop_n = 0; errs = 0;
      prev_bhs = 0; aw_wait_p = 0; w_wait_p = 0; prev_rst = 1;
    end else begin
      comp = done_n();
      outm = comp - b_n;
      err_exp = (errs > 65535) ? 16'hFFFF : 16'(errs);
      chk("outstanding", 64'(outstanding), 64'(outm));
      chk("out_le_max", 64'(outstanding <= 4'(MAXO)), 64'(1));
      chk("bready", 64'(BREADY), 64'(outm != 0));
      chk("cmd_ready", 64'(cmd_ready), 64'(!prev_rst && ((acc_n - comp) < DEPTH)));
      chk("idle", 64'(idle), 64'((acc_n == comp) && (outm == 0)));
      chk("rsp_valid", 64'(rsp_valid), 64'(prev_bhs));
      if (prev_bhs) chk("rsp_resp", 64'(rsp_resp), 64'(prev_bresp));
      chk("err_cnt", 64'(err_cnt), 64'(err_exp));
      if (aw_wait_p) begin
        chk("aw_hold_valid", 64'(AWVALID), 64'(1));
        chk("aw_hold_addr", 64'(AWADDR), 64'(awaddr_p));
      end
      if (w_wait_p) begin
        chk("w_hold_valid", 64'(WVALID), 64'(1));
        chk("w_hold_data", 64'(WDATA), 64'(wdata_p));
        chk("w_hold_strb", 64'(WSTRB), 64'(wstrb_p));
      end
      // Handshakes that complete at the coming rising edge
      if (AWVALID && AWREADY) begin
        idx = aw_n - pop_n;
        if (idx < exp_q.size()) chk("aw_addr", 64'(AWADDR), 64'(exp_q[idx].addr));
        else chk("aw_unexpected", 64'(1), 64'(0));
        aw_n++;
      end
      if (WVALID && WREADY) begin
        idx = w_n - pop_n;
        if (idx < exp_q.size()) begin
          chk("w_data", 64'(WDATA), 64'(exp_q[idx].data));
          chk("w_strb", 64'(WSTRB), 64'(exp_q[idx].strb));
        end else chk("w_unexpected", 64'(1), 64'(0));
        w_n++;
      end
      while (pop_n < done_n() && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        pop_n++;
      end
      prev_bhs = BVALID && BREADY;
      prev_bresp = BRESP;
      if (prev_bhs) begin
        b_n++;
        if (BRESP != 2'b00) errs++;
      end
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back('{cmd_addr, cmd_data, cmd_strb});
        acc_n++;
      end
      aw_wait_p = AWVALID && !AWREADY;
      w_wait_p  = WVALID && !WREADY;
      awaddr_p = AWADDR; wdata_p = WDATA; wstrb_p = WSTRB;
      prev_rst = 0;
    end
  end

  task automatic step();
    logic acc;
    @(negedge clk);
    acc = cmd_valid && cmd_ready;
    if (AWVALID && !WVALID) wait_aw_cyc++;
    @(posedge clk);
    #1;
    if (stream) begin
      if (acc || !cmd_valid) begin
        cmd_valid = 1'b1;
        cmd_addr = $urandom;
        cmd_data = $urandom;
        cmd_strb = 4'($urandom);
      end
    end else begin
      if (acc && pend_q.size() > 0) void'(pend_q.pop_front());
      if (pend_q.size() > 0) begin
        cmd_valid = 1'b1;
        cmd_addr = pend_q[0].addr;
        cmd_data = pend_q[0].data;
        cmd_strb = pend_q[0].strb;
      end else cmd_valid = 1'b0;
    end
    AWREADY = mode_v(awr_m);
    WREADY  = mode_v(wr_m);
    BVALID  = mode_v(bv_m);
    BRESP   = (br_m == 0) ? 2'b00 : (br_m == 1) ? 2'b10 : 2'($urandom);
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) pend_q.push_back('{$urandom, $urandom, 4'($urandom)});
  endtask

  task automatic drain(input string tag, input int maxc);
    int n;
    n = 0;
    while (n < maxc && !(pend_q.size() == 0 && !cmd_valid && acc_n == done_n() && done_n() == b_n)) begin
      step();
      n++;
    end
    chk(tag, 64'(n < maxc), 64'(1));
  endtask

  initial begin
    int base, n;
    cmd_valid = 0; cmd_addr = '0; cmd_data = '0; cmd_strb = '0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 2'b00;
    awr_m = 0; wr_m = 0; bv_m = 0; br_m = 0; stream = 0;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("ready_after_rst", 64'(cmd_ready), 64'(1));

    // Single write with ready slaves
    awr_m = 1; wr_m = 1; bv_m = 1; br_m = 0;
    pend_q.push_back('{32'h10, 32'hDEADBEEF, 4'hF});
    drain("single_drain", 50);
    chk("single_done", 64'(done_n()), 64'(1));
    chk("single_b", 64'(b_n), 64'(1));
    chk("single_out", 64'(outstanding), 64'(0));

    // W accepted well before AW
    awr_m = 0; wr_m = 1; wait_aw_cyc = 0;
    push_rand(1);
    n = 0;
    while (w_n < 2 && n < 20) begin step(); n++; end
    chk("skew_w_seen", 64'(w_n), 64'(2));
    repeat (3) step();
    awr_m = 1;
    drain("skew_drain", 50);
    chk("skew_wait_aw", 64'(wait_aw_cyc > 0), 64'(1));
    chk("skew_done", 64'(done_n()), 64'(2));

    // Back-pressure on B
    bv_m = 0;
    base = done_n();
    push_rand(8);
    repeat (30) step();
    chk("bp_outstanding", 64'(outstanding), 64'(MAXO));
    chk("bp_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("bp_issued", 64'(done_n() - base), 64'(4));
    bv_m = 1;
    drain("bp_drain", 100);
    chk("bp_all", 64'(b_n), 64'(base + 8));

    // Error responses
    br_m = 1;
    push_rand(3);
    drain("err_drain1", 100);
    br_m = 0;
    push_rand(1);
    drain("err_drain2", 100);
    chk("err_cnt_3", 64'(err_cnt), 64'(3));

    // Randomized traffic and slave behaviour
    awr_m = 2; wr_m = 2; bv_m = 2; br_m = 2;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) push_rand(1);
      step();
    end
    awr_m = 1; wr_m = 1; bv_m = 1;
    drain("rand_drain", 4000);

    // Reset with 2 writes in flight and 2 queued
    bv_m = 0; br_m = 0;
    push_rand(2);
    n = 0;
    while (done_n() - b_n < 2 && n < 30) begin step(); n++; end
    awr_m = 0; wr_m = 0;
    push_rand(2);
    repeat (4) step();
    chk("mid_outstanding", 64'(outstanding), 64'(2));
    chk("mid_idle", 64'(idle), 64'(0));
    rst = 1'b1;
    pend_q.delete();
    cmd_valid = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    bv_m = 1; br_m = 1;
    repeat (6) step();
    chk("late_b_err", 64'(err_cnt), 64'(0));
    chk("late_b_rsp", 64'(rsp_valid), 64'(0));
    chk("late_b_out", 64'(outstanding), 64'(0));

    // Continuous error stream to reach error counter saturation
    awr_m = 1; wr_m = 1; bv_m = 1; br_m = 1;
    stream = 1;
    repeat (65600) step();
    stream = 0;
    drain("sat_drain", 100);
    chk("sat_errs_exceed", 64'(errs > 65535), 64'(1));
    chk("sat_err_cnt", 64'(err_cnt), 64'(16'hFFFF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
